// File: rtl/icache_refill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl_pkg
// Shared types and constants for the instruction-cache refill path:
//   refill_state_e  - refill controller FSM states
//   AXI_BURST_INCR  - AXI ARBURST encoding for incrementing bursts
//   AXI_SIZE_4B     - AXI ARSIZE encoding for 4-byte beats
//   WORD_W          - width of one cache-line word / AXI data beat
// -----------------------------------------------------------------------------
package icache_refill_ctrl_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

   typedef enum logic [1:0] {
      REFILL_IDLE,
      REFILL_ADDR,
      REFILL_DATA,
      REFILL_DONE
   } refill_state_e;

endpackage

// File: rtl/icache_line_buffer.sv
// -----------------------------------------------------------------------------
// icache_line_buffer
// Assembles one cache line from individual 32-bit words.
// Ports:
//   clk_i    - clock
//   rst_ni   - asynchronous active-low reset, clears the line
//   clr_i    - synchronous clear of the whole line (has priority over we_i)
//   we_i     - write word idx_i with wdata_i
//   idx_i    - word index within the line
//   wdata_i  - word to write
//   line_o   - full line, word k at bits [32k+31:32k]
// -----------------------------------------------------------------------------
module icache_line_buffer
   import icache_refill_ctrl_pkg::*;
#(
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned IDX_W      = $clog2(LINE_WORDS)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clr_i,
   input  logic                         we_i,
   input  logic [IDX_W-1:0]             idx_i,
   input  logic [WORD_W-1:0]            wdata_i,
   output logic [LINE_WORDS*WORD_W-1:0] line_o
);

   logic [LINE_WORDS*WORD_W-1:0] line_q, line_d;

   always_comb begin
      line_d = line_q;
      if (clr_i) begin
         line_d = '0;
      end else if (we_i) begin
         for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            if (idx_i == IDX_W'(w)) begin
               line_d[w*WORD_W +: WORD_W] = wdata_i;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   assign line_o = line_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
// Turns an icache miss into a single AXI INCR read burst of LINE_WORDS beats
// and delivers the assembled line to the data/tag arrays.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   miss_req/miss_addr       - miss request from lookup; miss_ready = idle
//   flush                    - abandon current refill (burst still drained)
//   ar_*                     - AXI read-address channel (master side)
//   r_*                      - AXI read-data channel (master side)
//   refill_valid/addr/data/err - one-cycle line delivery
// -----------------------------------------------------------------------------
module icache_refill_ctrl
   import icache_refill_ctrl_pkg::*;
#(
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned ID         = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         miss_req,
   input  logic [ADDR_WIDTH-1:0]        miss_addr,
   output logic                         miss_ready,
   input  logic                         flush,
   output logic                         ar_valid,
   input  logic                         ar_ready,
   output logic [ADDR_WIDTH-1:0]        ar_addr,
   output logic [3:0]                   ar_id,
   output logic [7:0]                   ar_len,
   output logic [2:0]                   ar_size,
   output logic [1:0]                   ar_burst,
   input  logic                         r_valid,
   output logic                         r_ready,
   input  logic [31:0]                  r_data,
   input  logic [1:0]                   r_resp,
   input  logic                         r_last,
   output logic                         refill_valid,
   output logic [ADDR_WIDTH-1:0]        refill_addr,
   output logic [LINE_WORDS*32-1:0]     refill_data,
   output logic                         refill_err
);

   localparam int unsigned               BEAT_W     = $clog2(LINE_WORDS);
   localparam int unsigned               OFF_W      = $clog2(LINE_WORDS*4);
   localparam logic [BEAT_W-1:0]         LAST_BEAT  = BEAT_W'(LINE_WORDS-1);
   localparam logic [ADDR_WIDTH-1:0]     ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;

   refill_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
   logic                    abandon_q, abandon_d;
   logic                    err_q, err_d;
   logic                    lb_clr, lb_we;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      beat_cnt_d   = beat_cnt_q;
      abandon_d    = abandon_q;
      err_d        = err_q;
      lb_clr       = 1'b0;
      lb_we        = 1'b0;
      miss_ready   = 1'b0;
      ar_valid     = 1'b0;
      r_ready      = 1'b0;
      refill_valid = 1'b0;

      case (state_q)
         REFILL_IDLE: begin
            miss_ready = 1'b1;
            if (miss_req && !flush) begin
               addr_d     = miss_addr & ALIGN_MASK;
               beat_cnt_d = '0;
               err_d      = 1'b0;
               abandon_d  = 1'b0;
               lb_clr     = 1'b1;
               state_d    = REFILL_ADDR;
            end
         end
         REFILL_ADDR: begin
            // ar_valid may not be withdrawn once raised: flush only marks the
            // refill abandoned and lets the handshake complete.
            ar_valid = 1'b1;
            if (flush) abandon_d = 1'b1;
            if (ar_ready) state_d = REFILL_DATA;
         end
         REFILL_DATA: begin
            r_ready = 1'b1;
            if (flush) abandon_d = 1'b1;
            if (r_valid) begin
               lb_we      = 1'b1;
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (r_resp != 2'b00) err_d = 1'b1;
               // Termination follows the beat count; r_last only flags errors.
               if (beat_cnt_q == LAST_BEAT) begin
                  if (!r_last) err_d = 1'b1;
                  state_d = REFILL_DONE;
               end else if (r_last) begin
                  err_d = 1'b1;
               end
            end
         end
         REFILL_DONE: begin
            refill_valid = !abandon_q;
            abandon_d    = 1'b0;
            state_d      = REFILL_IDLE;
         end
         default: state_d = REFILL_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= REFILL_IDLE;
         addr_q     <= '0;
         beat_cnt_q <= '0;
         abandon_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         beat_cnt_q <= beat_cnt_d;
         abandon_q  <= abandon_d;
         err_q      <= err_d;
      end
   end

   icache_line_buffer #(
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (BEAT_W)
   ) u_line_buffer (
      .clk_i   (clk),
      .rst_ni  (rst),
      .clr_i   (lb_clr),
      .we_i    (lb_we),
      .idx_i   (beat_cnt_q),
      .wdata_i (r_data),
      .line_o  (refill_data)
   );

   assign ar_addr     = addr_q;
   assign ar_id       = 4'(ID);
   assign ar_len      = 8'(LINE_WORDS-1);
   assign ar_size     = AXI_SIZE_4B;
   assign ar_burst    = AXI_BURST_INCR;
   assign refill_addr = addr_q;
   assign refill_err  = err_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

   localparam int LW  = 8;
   localparam int AW  = 32;
   localparam int TID = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic              miss_req;
   logic [AW-1:0]     miss_addr;
   logic              miss_ready;
   logic              flush;
   logic              ar_valid;
   logic              ar_ready;
   logic [AW-1:0]     ar_addr;
   logic [3:0]        ar_id;
   logic [7:0]        ar_len;
   logic [2:0]        ar_size;
   logic [1:0]        ar_burst;
   logic              r_valid;
   logic              r_ready;
   logic [31:0]       r_data;
   logic [1:0]        r_resp;
   logic              r_last;
   logic              refill_valid;
   logic [AW-1:0]     refill_addr;
   logic [LW*32-1:0]  refill_data;
   logic              refill_err;

   icache_refill_ctrl #(
      .LINE_WORDS (LW),
      .ADDR_WIDTH (AW),
      .ID         (TID)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .miss_req     (miss_req),
      .miss_addr    (miss_addr),
      .miss_ready   (miss_ready),
      .flush        (flush),
      .ar_valid     (ar_valid),
      .ar_ready     (ar_ready),
      .ar_addr      (ar_addr),
      .ar_id        (ar_id),
      .ar_len       (ar_len),
      .ar_size      (ar_size),
      .ar_burst     (ar_burst),
      .r_valid      (r_valid),
      .r_ready      (r_ready),
      .r_data       (r_data),
      .r_resp       (r_resp),
      .r_last       (r_last),
      .refill_valid (refill_valid),
      .refill_addr  (refill_addr),
      .refill_data  (refill_data),
      .refill_err   (refill_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Scoreboard entries, all timed in absolute cycle numbers.
   typedef struct {
      int            t_start;
      int            t_ar;
      logic [AW-1:0] addr;
   } ar_exp_t;
   typedef struct {
      int               t;
      logic [AW-1:0]    addr;
      logic [LW*32-1:0] data;
      logic             err;
   } rf_exp_t;
   typedef struct {
      int t_acc;
      int t_data0;
      int t_done;
   } ph_exp_t;

   ar_exp_t arq[$];
   rf_exp_t rfq[$];
   ph_exp_t phq[$];

   // Beat contents for the next transaction.
   logic [31:0] bd[LW];
   logic [1:0]  br[LW];
   logic        bl[LW];

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (phq.size() != 0) begin
            check("r_ready", r_ready, 64'(cyc >= phq[0].t_data0 && cyc < phq[0].t_done));
            check("miss_ready", miss_ready, 64'(!(cyc > phq[0].t_acc && cyc <= phq[0].t_done)));
            if (cyc >= phq[0].t_done + 1) void'(phq.pop_front());
         end else begin
            check("r_ready_idle", r_ready, 0);
            check("miss_ready_idle", miss_ready, 1);
         end

         if (arq.size() != 0 && cyc >= arq[0].t_start) begin
            check("ar_valid", ar_valid, 1);
            check("ar_addr", ar_addr, arq[0].addr);
            check("ar_len", ar_len, LW - 1);
            check("ar_size", ar_size, 3'b010);
            check("ar_burst", ar_burst, 2'b01);
            check("ar_id", ar_id, TID);
            if (cyc >= arq[0].t_ar) void'(arq.pop_front());
         end else begin
            check("ar_valid_idle", ar_valid, 0);
         end

         if (rfq.size() != 0 && cyc == rfq[0].t) begin
            check("refill_valid", refill_valid, 1);
            check("refill_addr", refill_addr, rfq[0].addr);
            check("refill_err", refill_err, rfq[0].err);
            for (int k = 0; k < LW; k++)
               check("refill_word", refill_data[k*32 +: 32], rfq[0].data[k*32 +: 32]);
            void'(rfq.pop_front());
         end else begin
            check("refill_valid_idle", refill_valid, 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle_inputs();
      miss_req = 1'b0; miss_addr = '0; flush = 1'b0; ar_ready = 1'b0;
      r_valid = 1'b0; r_data = '0; r_resp = '0; r_last = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic set_beats();
      for (int k = 0; k < LW; k++) begin
         bd[k] = $urandom;
         br[k] = 2'b00;
         bl[k] = (k == LW - 1);
      end
   endtask

   // w: cycles ar_ready held low; g: idle cycles before each beat;
   // flush_sel: -1 none, -2 first ADDR cycle, k>=0 with beat k;
   // rst_beat: -1 none, k>=0 assert reset during beat k.
   task automatic run_txn(input logic [AW-1:0] addr, input int w, input int g,
                          input int flush_sel, input int rst_beat);
      int n, t_acc, t_ar, t_last;
      int bt[LW];
      logic err, do_rst;
      logic [LW*32-1:0] dat;
      ar_exp_t ea;
      rf_exp_t er;
      ph_exp_t ep;

      n = 0;
      while (miss_ready !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
      if (miss_ready !== 1'b1) begin
         check("miss_ready_timeout", 0, 1);
         return;
      end

      t_acc = cyc;
      t_ar  = t_acc + 1 + w;
      for (int k = 0; k < LW; k++) bt[k] = t_ar + 1 + g + k * (g + 1);
      t_last = bt[LW-1];

      err = 1'b0;
      for (int k = 0; k < LW; k++) begin
         dat[k*32 +: 32] = bd[k];
         if (br[k] != 2'b00) err = 1'b1;
         if (bl[k] != (k == LW - 1)) err = 1'b1;
      end

      ea.t_start = t_acc + 1;
      ea.t_ar    = t_ar;
      ea.addr    = addr & ~AW'(LW * 4 - 1);
      arq.push_back(ea);
      if (flush_sel == -1) begin
         er.t    = t_last + 1;
         er.addr = ea.addr;
         er.data = dat;
         er.err  = err;
         rfq.push_back(er);
      end
      ep.t_acc   = t_acc;
      ep.t_data0 = t_ar + 1;
      ep.t_done  = t_last + 1;
      phq.push_back(ep);

      miss_req  = 1'b1;
      miss_addr = addr;
      @(posedge clk); #1;
      miss_req  = 1'b0;
      miss_addr = $urandom;

      for (int c = t_acc + 1; c <= t_last; c++) begin
         ar_ready = (c == t_ar);
         r_valid  = 1'b0;
         r_data   = $urandom;
         r_resp   = 2'($urandom);
         r_last   = 1'($urandom);
         flush    = (flush_sel == -2 && c == t_acc + 1);
         do_rst   = 1'b0;
         for (int k = 0; k < LW; k++) begin
            if (c == bt[k]) begin
               r_valid = 1'b1;
               r_data  = bd[k];
               r_resp  = br[k];
               r_last  = bl[k];
               if (flush_sel == k) flush = 1'b1;
               if (rst_beat == k) do_rst = 1'b1;
            end
         end
         if (do_rst) begin
            #2 rst = 1'b0;
            #1;
            check("rst_ar_valid", ar_valid, 0);
            check("rst_r_ready", r_ready, 0);
            check("rst_refill_valid", refill_valid, 0);
            check("rst_refill_err", refill_err, 0);
            check("rst_miss_ready", miss_ready, 1);
            check("rst_refill_data", 64'(refill_data == '0), 1);
            check("rst_refill_addr", refill_addr, 0);
            arq.delete(); rfq.delete(); phq.delete();
            idle_inputs();
            @(posedge clk); #1;
            rst = 1'b1;
            return;
         end
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

   initial begin
      int fs, r, j;
      rst = 1'b0;
      idle_inputs();
      idle_cycles(3);
      check("reset_miss_ready", miss_ready, 1);
      check("reset_ar_valid", ar_valid, 0);
      check("reset_r_ready", r_ready, 0);
      check("reset_refill_valid", refill_valid, 0);
      check("reset_refill_err", refill_err, 0);
      check("reset_refill_data", 64'(refill_data == '0), 1);
      check("reset_refill_addr", refill_addr, 0);
      rst = 1'b1;
      idle_cycles(1);

      // Basic line 0x11..0x88, minimum latency.
      set_beats();
      for (int k = 0; k < LW; k++) bd[k] = 32'h11 * (k + 1);
      run_txn(32'h8000_1234, 0, 0, -1, -1);

      // Address channel back-pressure.
      set_beats();
      run_txn(32'h0000_4F7C, 5, 0, -1, -1);

      // Beats every third cycle.
      set_beats();
      run_txn(32'h1234_5678, 0, 2, -1, -1);

      // Flush during ADDR.
      set_beats();
      run_txn(32'hDEAD_BEEF, 2, 0, -2, -1);

      // SLVERR on beat 3.
      set_beats();
      br[3] = 2'b10;
      run_txn(32'h0000_0040, 0, 0, -1, -1);

      // Early r_last on beat 5.
      set_beats();
      bl[5] = 1'b1;
      run_txn(32'h0000_1000, 0, 1, -1, -1);

      // Missing r_last on final beat.
      set_beats();
      bl[LW-1] = 1'b0;
      run_txn(32'hFFFF_FFFF, 1, 0, -1, -1);

      // Flush together with the final beat, then flush mid-DATA.
      set_beats();
      run_txn(32'h0BAD_0000, 0, 0, LW - 1, -1);
      set_beats();
      run_txn(32'h0BAD_1000, 0, 1, 2, -1);

      // Flush in IDLE blocks a simultaneous miss.
      idle_cycles(2);
      miss_req = 1'b1; flush = 1'b1; miss_addr = 32'h5555_5555;
      @(posedge clk); #1;
      idle_inputs();
      check("idle_flush_miss_ready", miss_ready, 1);
      check("idle_flush_ar_valid", ar_valid, 0);

      // Reset during beat 4 (refill_err already set by beat 1), then a fresh miss.
      set_beats();
      br[1] = 2'b11;
      run_txn(32'h7777_0000, 0, 0, -1, 4);
      set_beats();
      run_txn(32'h3333_3330, 0, 0, -1, -1);

      for (int i = 0; i < 30; i++) begin
         set_beats();
         if ($urandom_range(0, 9) == 0) br[$urandom_range(0, LW - 1)] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) begin
            j = $urandom_range(0, LW - 1);
            bl[j] = !bl[j];
         end
         fs = -1;
         r = $urandom_range(0, 9);
         if (r == 0) fs = -2;
         else if (r == 1) fs = $urandom_range(0, LW - 1);
         run_txn($urandom, $urandom_range(0, 4), $urandom_range(0, 3), fs, -1);
         idle_cycles($urandom_range(0, 2));
      end

      idle_cycles(4);
      check("scoreboard_drained", arq.size() + rfq.size() + phq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
